// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg -- shared types and helpers for the M-stage data-memory
// controller.
//   state_t      : controller FSM states (IDLE / REQ / DONE)
//   size_t       : access size decoded from the byte enables
//   BE_*         : legal byte-enable patterns
//   be_is_legal  : 1 when a byte-enable pattern is one of the legal ones
//   be_to_size   : byte enables -> access size (illegal patterns map to WORD)
//   be_low_lane  : index of the lowest enabled byte lane
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  function automatic logic be_is_legal(input logic [3:0] be);
    logic ok;
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3,
      BE_H0, BE_H1, BE_W: ok = 1'b1;
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic size_t be_to_size(input logic [3:0] be);
    size_t sz;
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3: sz = BYTE;
      BE_H0, BE_H1:               sz = HALF;
      default:                    sz = WORD;
    endcase
    return sz;
  endfunction

  function automatic logic [1:0] be_low_lane(input logic [3:0] be);
    logic [1:0] lane;
    if (be[0])      lane = 2'd0;
    else if (be[1]) lane = 2'd1;
    else if (be[2]) lane = 2'd2;
    else            lane = 2'd3;
    return lane;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align -- purely combinational byte-lane steering.
//   be        in  4   byte enables of the access
//   ld_signed in  1   1 = sign-extend loads, 0 = zero-extend
//   st_data   in  32  LSB-justified store data
//   ld_raw    in  32  raw word returned by the bus
//   st_lanes  out 32  store data replicated onto every lane
//   ld_data   out 32  load data shifted down from the lowest enabled lane
//                     and extended to 32 bits
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [3:0]  be,
  input  logic        ld_signed,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  size_t       size;
  logic [1:0]  lane;
  logic [31:0] shifted;

  always_comb begin
    size     = be_to_size(be);
    lane     = be_low_lane(be);
    shifted  = ld_raw >> {lane, 3'b000};
    st_lanes = st_data;
    ld_data  = shifted;
    case (size)
      BYTE: begin
        st_lanes = {4{st_data[7:0]}};
        ld_data  = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        st_lanes = {2{st_data[15:0]}};
        ld_data  = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl -- data-memory access controller behind the M stage.
// Takes one M-stage load/store, runs a valid/ack cycle on the data bus and
// holds the pipeline until the access completes.
//   clk, reset            clock; synchronous active-low reset
//   MemWriteM, MemtoRegM  store / load request (store wins if both set)
//   LoadSignedM           sign-extend loads
//   ByteEnM               lane enables (legal: single byte, aligned half, word)
//   ALUResultM            byte address
//   WriteDataM            LSB-justified store data
//   ReadDataM             aligned, extended load data, valid in DONE
//   StallM                freezes the pipeline registers
//   MemErrM               one-cycle error pulse in DONE
//   bus_req/we/addr/wdata/be   bus request side
//   bus_ack/err/rdata          bus response side (err/rdata qualified by ack)
// Build option MEM_TIMEOUT_EN: adds output MemTimeoutSticky; an unanswered
// request is abandoned with an error after TIMEOUT_CYCLES REQ cycles.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic        LoadSignedM,
  input  logic [3:0]  ByteEnM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemErrM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
`ifdef MEM_TIMEOUT_EN
  ,
  output logic        MemTimeoutSticky
`endif
);

  state_t      state, state_n;
  logic        access;
  logic        be_ok;
  logic        cap_req;
  logic        cap_illegal;
  logic        cap_ack;
  logic        tmo_hit;

  logic        h_we;
  logic        h_load;
  logic        h_signed;
  logic        h_err;
  logic [3:0]  h_be;
  logic [31:0] h_addr;
  logic [31:0] h_wdata;
  logic [31:0] h_rdata;

  logic [31:0] st_lanes;
  logic [31:0] ld_data;

  // Word-aligned bus: the two address LSBs are carried by the byte enables.
  logic        unused_addr_lsb;
  assign unused_addr_lsb = ^ALUResultM[1:0];

  assign access = MemWriteM | MemtoRegM;
  assign be_ok  = be_is_legal(ByteEnM);

`ifdef MEM_TIMEOUT_EN
  logic [31:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (cap_req) begin
      wait_cnt <= '0;
    end else if (state == REQ && !bus_ack) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

  assign tmo_hit = (state == REQ) && !bus_ack && (wait_cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      MemTimeoutSticky <= 1'b0;
    end else if (tmo_hit) begin
      MemTimeoutSticky <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    StallM      = 1'b0;
    bus_req     = 1'b0;
    cap_req     = 1'b0;
    cap_illegal = 1'b0;
    cap_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          StallM = 1'b1;
          if (be_ok) begin
            cap_req = 1'b1;
            state_n = REQ;
          end else begin
            // Illegal enables never reach the bus; report straight away.
            cap_illegal = 1'b1;
            state_n     = DONE;
          end
        end
      end
      REQ: begin
        bus_req = 1'b1;
        StallM  = 1'b1;
        if (bus_ack) begin
          cap_ack = 1'b1;
          state_n = DONE;
        end else if (tmo_hit) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Holding registers: request fields are frozen for the whole REQ phase,
  // response fields are frozen for the DONE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_we     <= 1'b0;
      h_load   <= 1'b0;
      h_signed <= 1'b0;
      h_err    <= 1'b0;
      h_be     <= '0;
      h_addr   <= '0;
      h_wdata  <= '0;
      h_rdata  <= '0;
    end else if (cap_req) begin
      h_we     <= MemWriteM;
      h_load   <= MemtoRegM & ~MemWriteM;
      h_signed <= LoadSignedM;
      h_err    <= 1'b0;
      h_be     <= ByteEnM;
      h_addr   <= {ALUResultM[31:2], 2'b00};
      h_wdata  <= WriteDataM;
    end else if (cap_illegal) begin
      h_load <= 1'b0;
      h_err  <= 1'b1;
    end else if (cap_ack) begin
      h_rdata <= bus_rdata;
      h_err   <= bus_err;
    end else if (tmo_hit) begin
      h_err <= 1'b1;
    end
  end

  mem_lane_align u_align (
    .be        (h_be),
    .ld_signed (h_signed),
    .st_data   (h_wdata),
    .ld_raw    (h_rdata),
    .st_lanes  (st_lanes),
    .ld_data   (ld_data)
  );

  assign bus_we    = h_we;
  assign bus_addr  = h_addr;
  assign bus_be    = h_be;
  assign bus_wdata = st_lanes;

  assign ReadDataM = (state == DONE && h_load && !h_err) ? ld_data : '0;
  assign MemErrM   = (state == DONE) && h_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: randomized and directed loads/stores against
// a behavioural bus slave, with a queue-based scoreboard checked by a
// separate monitor. Build with +define+MEM_TIMEOUT_EN to cover the timeout.
module tb_mem_stage_ctrl;

  localparam int unsigned TMO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WAIT_LIMIT = TMO;
  localparam int unsigned RAND_DELAY_MAX = TMO;
`else
  localparam int unsigned WAIT_LIMIT = 32'hFFFF_FFFF;
  localparam int unsigned RAND_DELAY_MAX = TMO + 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemtoRegM, LoadSignedM;
  logic [3:0]  ByteEnM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MemErrM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;
`ifdef MEM_TIMEOUT_EN
  logic        sticky;
`endif

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemWriteM   (MemWriteM),
    .MemtoRegM   (MemtoRegM),
    .LoadSignedM (LoadSignedM),
    .ByteEnM     (ByteEnM),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .ReadDataM   (ReadDataM),
    .StallM      (StallM),
    .MemErrM     (MemErrM),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_be      (bus_be),
    .bus_ack     (bus_ack),
    .bus_err     (bus_err),
    .bus_rdata   (bus_rdata)
`ifdef MEM_TIMEOUT_EN
    ,
    .MemTimeoutSticky (sticky)
`endif
  );

  typedef struct {
    logic        we;
    logic        ld;
    logic        sgn;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int unsigned delay;   // REQ cycle carrying ack (1 = first), 0 = never
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } req_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned stalls;
  } done_exp_t;

  req_exp_t  req_q[$];
  done_exp_t done_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- bus slave ----------------
  int unsigned cur_delay = 1;
  logic        cur_err = 1'b0;
  logic [31:0] cur_rdata = '0;
  logic        force_ack = 1'b0;

  initial begin
    int unsigned req_cycles;
    req_cycles = 0;
    bus_ack = 1'b0;
    bus_err = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_req === 1'b1) begin
        req_cycles++;
        if (req_cycles == cur_delay) begin
          bus_ack   = 1'b1;
          bus_err   = cur_err;
          bus_rdata = cur_rdata;
        end else begin
          bus_ack   = 1'b0;
          bus_err   = 1'($urandom_range(0, 1));
          bus_rdata = $urandom;
        end
      end else begin
        // Stray acks outside a request must be ignored by the controller.
        req_cycles = 0;
        bus_ack   = force_ack | ($urandom_range(0, 3) == 0);
        bus_err   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic mon_en = 1'b0;

  initial begin
    int unsigned stall_run;
    logic        prev_req;
    req_exp_t    cur_req;
    done_exp_t   de;
    stall_run = 0;
    prev_req  = 1'b0;
    cur_req   = '{addr: '0, wdata: '0, be: '0, we: 1'b0};
    forever begin
      @(negedge clk);
      if (!mon_en || reset !== 1'b1) begin
        stall_run = 0;
        prev_req  = 1'b0;
      end else begin
        if (bus_req === 1'b1) begin
          if (!prev_req) begin
            if (req_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_req: got bus_req=1 expected no request (t=%0t)", $time);
            end else begin
              cur_req = req_q.pop_front();
            end
          end
          chk("bus_addr", bus_addr, cur_req.addr);
          chk("bus_wdata", bus_wdata, cur_req.wdata);
          chk("bus_be", {28'd0, bus_be}, {28'd0, cur_req.be});
          chk("bus_we", {31'd0, bus_we}, {31'd0, cur_req.we});
        end
        if (StallM === 1'b1) begin
          stall_run++;
        end else if (stall_run != 0) begin
          if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got completion expected none (t=%0t)", $time);
          end else begin
            de = done_q.pop_front();
            chk("ReadDataM", ReadDataM, de.rdata);
            chk("MemErrM", {31'd0, MemErrM}, {31'd0, de.err});
            chk("stall_cycles", stall_run, de.stalls);
            chk("done_bus_req", {31'd0, bus_req}, 32'd0);
          end
          stall_run = 0;
        end else begin
          chk("idle_memerr", {31'd0, MemErrM}, 32'd0);
          chk("idle_rdata", ReadDataM, 32'd0);
          chk("idle_req", {31'd0, bus_req}, 32'd0);
        end
        prev_req = (bus_req === 1'b1);
      end
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic idle_inputs();
    MemWriteM   = 1'b0;
    MemtoRegM   = 1'b0;
    LoadSignedM = 1'($urandom_range(0, 1));
    ByteEnM     = 4'($urandom_range(0, 15));
    ALUResultM  = $urandom;
    WriteDataM  = $urandom;
  endtask

  task automatic issue(input txn_t t);
    logic        legal, acked, is_load, got;
    int unsigned nb, lane;
    logic [31:0] v;
    req_exp_t    r;
    done_exp_t   d;

    legal   = t.be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    nb      = $countones(t.be);
    lane    = 0;
    while (lane < 3 && !t.be[lane]) lane++;
    is_load = t.ld && !t.we;
    acked   = (t.delay != 0) && (t.delay <= WAIT_LIMIT);

    if (legal) begin
      r.addr  = t.addr & 32'hFFFF_FFFC;
      if (nb == 1)      r.wdata = (t.wdata & 32'h0000_00FF) * 32'h0101_0101;
      else if (nb == 2) r.wdata = (t.wdata & 32'h0000_FFFF) * 32'h0001_0001;
      else              r.wdata = t.wdata;
      r.be = t.be;
      r.we = t.we;
      req_q.push_back(r);
      d.stalls = acked ? 1 + t.delay : 1 + WAIT_LIMIT;
    end else begin
      d.stalls = 1;
    end
    d.err = !legal || !acked || t.err;
    v = t.rdata >> (8 * lane);
    if (nb == 1) begin
      v = v & 32'h0000_00FF;
      if (t.sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (nb == 2) begin
      v = v & 32'h0000_FFFF;
      if (t.sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    d.rdata = (is_load && !d.err) ? v : 32'd0;
    done_q.push_back(d);

    cur_delay   = t.delay;
    cur_err     = t.err;
    cur_rdata   = t.rdata;
    MemWriteM   = t.we;
    MemtoRegM   = t.ld;
    LoadSignedM = t.sgn;
    ByteEnM     = t.be;
    ALUResultM  = t.addr;
    WriteDataM  = t.wdata;

    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (StallM !== 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: got no completion expected one within 300 cycles");
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  function automatic txn_t mk(input logic we, input logic ld, input logic sgn,
                              input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err, input int unsigned delay);
    txn_t t;
    t.we = we; t.ld = ld; t.sgn = sgn; t.be = be; t.addr = addr;
    t.wdata = wdata; t.rdata = rdata; t.err = err; t.delay = delay;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] legal_be[7];
    txn_t       t;
    int unsigned op, gap;
    legal_be = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    reset = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_memerr", {31'd0, MemErrM}, 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
`ifdef MEM_TIMEOUT_EN
    chk("rst_sticky", {31'd0, sticky}, 32'd0);
`endif
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // directed cases
    issue(mk(1, 0, 0, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 2));
    issue(mk(0, 1, 1, 4'b1000, 32'h0000_0203, 32'h0, 32'h8011_2233, 0, 1));
    issue(mk(0, 1, 0, 4'b1000, 32'h0000_0203, 32'h0, 32'h8011_2233, 0, 1));
    issue(mk(1, 0, 0, 4'b1100, 32'h0000_0302, 32'h0000_ABCD, 32'h0, 0, 1));
    issue(mk(0, 1, 0, 4'b1100, 32'h0000_0302, 32'h0, 32'hABCD_1234, 0, 1));
    issue(mk(0, 1, 1, 4'b1100, 32'h0000_0302, 32'h0, 32'hABCD_1234, 0, 3));
    issue(mk(0, 1, 0, 4'b0110, 32'h0000_0401, 32'h0, 32'h1234_5678, 0, 1));
    issue(mk(1, 1, 0, 4'b0010, 32'h0000_0501, 32'h0000_0077, 32'hFFFF_FFFF, 0, 1));
    issue(mk(0, 1, 1, 4'b0001, 32'h0000_0600, 32'h0, 32'h0000_00F0, 1, 2));
    issue(mk(1, 0, 0, 4'b0000, 32'h0000_0700, 32'h1111_2222, 32'h0, 0, 1));

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      t.we    = (op != 1);
      t.ld    = (op != 0);
      t.sgn   = 1'($urandom_range(0, 1));
      t.be    = ($urandom_range(0, 3) != 0) ? legal_be[$urandom_range(0, 6)] : 4'($urandom_range(0, 15));
      t.addr  = $urandom;
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.err   = ($urandom_range(0, 7) == 0);
      t.delay = $urandom_range(1, RAND_DELAY_MAX);
      issue(t);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end

`ifdef MEM_TIMEOUT_EN
    chk("sticky_before_timeout", {31'd0, sticky}, 32'd0);
    issue(mk(0, 1, 0, 4'b1111, 32'h0000_0800, 32'h0, 32'hCAFE_F00D, 0, 0));
    chk("sticky_after_timeout", {31'd0, sticky}, 32'd1);
    issue(mk(0, 1, 0, 4'b1111, 32'h0000_0804, 32'h0, 32'h0BAD_F00D, 0, TMO));
    chk("sticky_holds", {31'd0, sticky}, 32'd1);
`endif

    repeat (2) @(negedge clk);
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("done_q_drained", done_q.size(), 32'd0);

    // reset in the middle of a pending request
    @(posedge clk);
    #1;
    mon_en      = 1'b0;
    cur_delay   = 50;
    MemWriteM   = 1'b0;
    MemtoRegM   = 1'b1;
    ByteEnM     = 4'b1111;
    ALUResultM  = 32'h0000_0400;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_reset_req", {31'd0, bus_req}, 32'd1);
    reset     = 1'b0;
    MemtoRegM = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("midrst_stall", {31'd0, StallM}, 32'd0);
    chk("midrst_bus_addr", bus_addr, 32'd0);
    chk("midrst_bus_be", {28'd0, bus_be}, 32'd0);
`ifdef MEM_TIMEOUT_EN
    chk("midrst_sticky", {31'd0, sticky}, 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req", {31'd0, bus_req}, 32'd0);
    chk("late_ack_stall", {31'd0, StallM}, 32'd0);
    chk("late_ack_memerr", {31'd0, MemErrM}, 32'd0);
    chk("late_ack_rdata", ReadDataM, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
